// File: rtl/com_to_in.sv
// Serial byte receiver for out_to_com frames; even parity bit added when COM_TO_IN_PARITY_EN is defined.
// Byte is valid about 9.5 bit periods + 3 cycles after the start edge; held byte waits for ack, overwrite sets sticky overrun.
module com_to_in #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx,
   input  logic       ack,
   output logic [7:0] data,
   output logic       isValid,
   output logic       frameError,
   output logic       parityError,
   output logic       overrun,
   output logic [9:0] byteCount
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

`ifdef COM_TO_IN_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

   state_t        state, stateNxt;
   logic          rxMeta, rxs, rxPrev;
   logic [CW-1:0] cnt, cntNxt;
   logic [2:0]    bitIdx, bitIdxNxt;
   logic [7:0]    shiftReg;
   logic          sampleData;
   logic          frameDone;
`ifdef COM_TO_IN_PARITY_EN
   logic          parBit;
   logic          sampleParity;
`endif

   always_comb begin
      stateNxt   = state;
      cntNxt     = cnt + CW'(1);
      bitIdxNxt  = bitIdx;
      sampleData = 1'b0;
      frameDone  = 1'b0;
`ifdef COM_TO_IN_PARITY_EN
      sampleParity = 1'b0;
`endif
      case (state)
         IDLE: begin
            cntNxt = '0;
            if (rxPrev && !rxs) stateNxt = START;
         end
         START: begin
            // Mid-start sample: a line already back high was only a glitch.
            if (cnt == HALF_CNT) begin
               cntNxt    = '0;
               bitIdxNxt = '0;
               stateNxt  = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == LAST_CNT) begin
               cntNxt     = '0;
               sampleData = 1'b1;
               bitIdxNxt  = bitIdx + 3'd1;
               if (bitIdx == 3'd7) begin
`ifdef COM_TO_IN_PARITY_EN
                  stateNxt = PARITY;
`else
                  stateNxt = STOP;
`endif
               end
            end
         end
`ifdef COM_TO_IN_PARITY_EN
         PARITY: begin
            if (cnt == LAST_CNT) begin
               cntNxt       = '0;
               sampleParity = 1'b1;
               stateNxt     = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt == LAST_CNT) begin
               cntNxt    = '0;
               frameDone = 1'b1;
               stateNxt  = rxs ? IDLE : WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            cntNxt = '0;
            if (rxs) stateNxt = IDLE;
         end
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rxMeta     <= 1'b1;
         rxs        <= 1'b1;
         rxPrev     <= 1'b1;
         state      <= IDLE;
         cnt        <= '0;
         bitIdx     <= '0;
         shiftReg   <= '0;
         data       <= '0;
         isValid    <= 1'b0;
         frameError <= 1'b0;
         overrun    <= 1'b0;
         byteCount  <= '0;
`ifdef COM_TO_IN_PARITY_EN
         parBit      <= 1'b0;
         parityError <= 1'b0;
`endif
      end else begin
         rxMeta <= rx;
         rxs    <= rxMeta;
         rxPrev <= rxs;
         state  <= stateNxt;
         cnt    <= cntNxt;
         bitIdx <= bitIdxNxt;
         if (sampleData) shiftReg <= {rxs, shiftReg[7:1]};
`ifdef COM_TO_IN_PARITY_EN
         if (sampleParity) parBit <= rxs;
`endif
         // A completing frame wins over ack: the new byte stays valid.
         if (frameDone) begin
            data       <= shiftReg;
            frameError <= ~rxs;
            isValid    <= 1'b1;
            byteCount  <= byteCount + 10'd1;
            if (isValid && !ack) overrun <= 1'b1;
`ifdef COM_TO_IN_PARITY_EN
            parityError <= ^{shiftReg, parBit};
`endif
         end else if (ack) begin
            isValid <= 1'b0;
         end
      end
   end

`ifndef COM_TO_IN_PARITY_EN
   assign parityError = 1'b0;
`endif

endmodule

// File: tb/tb_com_to_in.sv
// Scoreboard bench for com_to_in: drivers push expected completions, monitors compare on each byteCount step.
// Unit A runs at 16 clocks/bit for the directed cases; unit B runs at 4 clocks/bit for the 1025-frame wrap.
module tb_com_to_in;

   localparam int CPB   = 16;
   localparam int CPB_B = 4;
`ifdef COM_TO_IN_PARITY_EN
   localparam int NB     = 11;
   localparam bit PAR_ON = 1'b1;
`else
   localparam int NB     = 10;
   localparam bit PAR_ON = 1'b0;
`endif
   localparam int STOP_OFS = (NB - 1) * CPB;

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       pe;
      logic       ovr;
      logic [9:0] cnt;
   } exp_t;

   logic       clk;
   logic       reset_n;
   logic       rx, ack;
   logic [7:0] data;
   logic       isValid, frameError, parityError, overrun;
   logic [9:0] byteCount;
   logic       rxB, ackB;
   logic [7:0] dataB;
   logic       isValidB, frameErrorB, parityErrorB, overrunB;
   logic [9:0] byteCountB;

   exp_t       qA[$];
   exp_t       qB[$];
   int         checks = 0;
   int         errors = 0;
   logic       mValid, mOvr;
   logic [9:0] mCount;

   com_to_in #(.CLKS_PER_BIT(CPB)) dutA (
      .clk(clk), .reset_n(reset_n), .rx(rx), .ack(ack),
      .data(data), .isValid(isValid), .frameError(frameError),
      .parityError(parityError), .overrun(overrun), .byteCount(byteCount)
   );

   com_to_in #(.CLKS_PER_BIT(CPB_B)) dutB (
      .clk(clk), .reset_n(reset_n), .rx(rxB), .ack(ackB),
      .data(dataB), .isValid(isValidB), .frameError(frameErrorB),
      .parityError(parityErrorB), .overrun(overrunB), .byteCount(byteCountB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic sendA(input logic [7:0] d, input logic par, input logic stopBit, input logic ackDone);
      exp_t          e;
      logic [NB-1:0] fb;
`ifdef COM_TO_IN_PARITY_EN
      fb = {stopBit, par, d, 1'b0};
`else
      fb = {stopBit, d, 1'b0};
`endif
      e.d   = d;
      e.fe  = ~stopBit;
      e.pe  = PAR_ON ? ^{d, par} : 1'b0;
      e.ovr = mOvr | (mValid & ~ackDone);
      e.cnt = mCount + 10'd1;
      qA.push_back(e);
      mValid = 1'b1;
      mOvr   = e.ovr;
      mCount = e.cnt;
      for (int c = 0; c < NB * CPB; c++) begin
         @(negedge clk);
         rx  = fb[c / CPB];
         ack = ackDone && (c == STOP_OFS + 10);
      end
      if (!stopBit) repeat (40 - CPB) @(negedge clk);
      @(negedge clk);
      ack = 1'b0;
      rx  = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic sendAbortA(input logic [7:0] d, input int abortBit);
      logic [9:0] fb;
      fb = {1'b1, d, 1'b0};
      for (int c = 0; c < (abortBit + 1) * CPB + 8; c++) begin
         @(negedge clk);
         rx = fb[c / CPB];
      end
      reset_n = 1'b0;
      rx      = 1'b1;
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      mValid  = 1'b0;
      mOvr    = 1'b0;
      mCount  = '0;
      repeat (20) @(negedge clk);
   endtask

   task automatic sendB(input logic [7:0] d, input int idx);
      exp_t          e;
      logic [NB-1:0] fb;
`ifdef COM_TO_IN_PARITY_EN
      fb = {1'b1, ^d, d, 1'b0};
`else
      fb = {1'b1, d, 1'b0};
`endif
      e.d   = d;
      e.fe  = 1'b0;
      e.pe  = 1'b0;
      e.ovr = (idx > 0);
      e.cnt = 10'(idx + 1);
      qB.push_back(e);
      for (int c = 0; c < NB * CPB_B; c++) begin
         @(negedge clk);
         rxB = fb[c / CPB_B];
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic pulseAck();
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      mValid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic doReset();
      @(negedge clk);
      reset_n = 1'b0;
      rx      = 1'b1;
      ack     = 1'b0;
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      mValid  = 1'b0;
      mOvr    = 1'b0;
      mCount  = '0;
      repeat (4) @(negedge clk);
   endtask

   initial begin : monA
      logic [9:0] prevA;
      exp_t       e;
      prevA = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!reset_n) begin
            prevA = byteCount;
         end else if (byteCount !== prevA) begin
            prevA = byteCount;
            if (qA.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL A unexpected completion: byteCount %0d with none pending", byteCount);
            end else begin
               e = qA.pop_front();
               check("A data", 32'(data), 32'(e.d));
               check("A isValid", 32'(isValid), 32'(1'b1));
               check("A frameError", 32'(frameError), 32'(e.fe));
               check("A parityError", 32'(parityError), 32'(e.pe));
               check("A overrun", 32'(overrun), 32'(e.ovr));
               check("A byteCount", 32'(byteCount), 32'(e.cnt));
            end
         end
      end
   end

   initial begin : monB
      logic [9:0] prevB;
      exp_t       e;
      prevB = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!reset_n) begin
            prevB = byteCountB;
         end else if (byteCountB !== prevB) begin
            prevB = byteCountB;
            if (qB.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL B unexpected completion: byteCount %0d with none pending", byteCountB);
            end else begin
               e = qB.pop_front();
               check("B data", 32'(dataB), 32'(e.d));
               check("B flags", 32'({isValidB, frameErrorB, parityErrorB, overrunB}),
                     32'({1'b1, e.fe, e.pe, e.ovr}));
               check("B byteCount", 32'(byteCountB), 32'(e.cnt));
            end
         end
      end
   end

   initial begin
      rx      = 1'b1;
      ack     = 1'b0;
      rxB     = 1'b1;
      ackB    = 1'b0;
      reset_n = 1'b0;
      mValid  = 1'b0;
      mOvr    = 1'b0;
      mCount  = '0;
      repeat (3) @(negedge clk);
      check("reset data", 32'(data), 32'h0);
      check("reset isValid", 32'(isValid), 32'h0);
      check("reset frameError", 32'(frameError), 32'h0);
      check("reset parityError", 32'(parityError), 32'h0);
      check("reset overrun", 32'(overrun), 32'h0);
      check("reset byteCount", 32'(byteCount), 32'h0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // Three-cycle low glitch on an idle line.
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch isValid", 32'(isValid), 32'h0);
      check("glitch byteCount", 32'(byteCount), 32'h0);

      sendA(8'hA5, ^8'hA5, 1'b1, 1'b0);
      check("A5 held isValid", 32'(isValid), 32'h1);
      check("A5 held data", 32'(data), 32'hA5);
      pulseAck();
      check("A5 acked isValid", 32'(isValid), 32'h0);
      check("A5 acked data", 32'(data), 32'hA5);
      pulseAck();
      check("idle ack isValid", 32'(isValid), 32'h0);
      check("idle ack data", 32'(data), 32'hA5);
      check("idle ack overrun", 32'(overrun), 32'h0);
      check("idle ack byteCount", 32'(byteCount), 32'h1);

      sendA(8'h3C, ^8'h3C, 1'b0, 1'b0);
      pulseAck();
      sendA(8'h01, ^8'h01, 1'b1, 1'b0);
      pulseAck();

      doReset();
      sendA(8'h11, ^8'h11, 1'b1, 1'b0);
      sendA(8'h22, ^8'h22, 1'b1, 1'b0);
      pulseAck();
      check("overrun sticky", 32'(overrun), 32'h1);
      check("overrun acked isValid", 32'(isValid), 32'h0);

      doReset();
      sendA(8'h11, ^8'h11, 1'b1, 1'b0);
      sendA(8'h22, ^8'h22, 1'b1, 1'b1);
      check("coincident ack isValid", 32'(isValid), 32'h1);
      check("coincident ack overrun", 32'(overrun), 32'h0);
      pulseAck();

`ifdef COM_TO_IN_PARITY_EN
      sendA(8'h07, 1'b1, 1'b1, 1'b0);
      pulseAck();
      sendA(8'h07, 1'b0, 1'b1, 1'b0);
      pulseAck();
`endif

      sendAbortA(8'hFF, 4);
      check("abort data", 32'(data), 32'h0);
      check("abort flags", 32'({isValid, frameError, parityError, overrun}), 32'h0);
      check("abort byteCount", 32'(byteCount), 32'h0);
      sendA(8'h5A, ^8'h5A, 1'b1, 1'b0);
      check("after abort byteCount", 32'(byteCount), 32'h1);

      for (int i = 0; i < 1025; i++) sendB(i[7:0], i);
      check("wrap byteCount", 32'(byteCountB), 32'h1);

      repeat (10) @(negedge clk);
      check("A pending", 32'(qA.size()), 32'h0);
      check("B pending", 32'(qB.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
